gpio_bank: RTL and testbench
============================

// Module: gpio_bank
// PURPOSE
//   Parametrised memory-mapped GPIO bank on the picoRV native bus: NUM_PINS tri-state pads with
//   per-pin mode (input / output / alternate-function bridge / open-drain), atomic SET/CLR of
//   the output latch, synchronised input sampling, per-pin rise/fall edge detection, and a
//   level interrupt to the CPU. Successor to the fixed 16-pin GPIO peripheral.
// PARAMETERS
//   NUM_PINS     16   pad count, 1..16 (MODE packs 2 bits/pin into one 32-bit word)
//   SYNC_STAGES  2    input synchroniser depth, 2..3
//   OUT_RESET    0    reset value of OUT latch, NUM_PINS bits
// PORTS
//   clk           in     1         system clock; single clock domain
//   reset         in     1         synchronous, active-high reset
//   select        in     1         bus request; held high until ready
//   wstrb         in     4         byte write strobes; 0 = read
//   addr          in     5         byte address; bits [1:0] ignored
//   data_i        in     32        write data
//   ready         out    1         one-cycle bus completion pulse
//   data_o        out    32        read data, valid while ready=1
//   gpio          inout  NUM_PINS  pads
//   af_oe         in     NUM_PINS  alternate-function output enable (bridge mode)
//   af_for_gpio   in     NUM_PINS  alternate-function output value
//   af_from_gpio  out    NUM_PINS  synchronised pad value to AF logic (0 when pin not in bridge)
//   irq           out    1         level interrupt = |(IRQ_STAT & (RISE_EN | FALL_EN))
// BEHAVIOUR
//   Reset (sync, active-high): MODE=0 (all input), OUT=OUT_RESET, RISE_EN=FALL_EN=IRQ_STAT=0,
//   synchroniser and edge history=0, ready=0, data_o=0, irq=0. Held reset: pads Z.
//   Register map (32-bit; bits >= NUM_PINS, or >= 2*NUM_PINS for MODE, read 0, ignore writes):
//     0x00 MODE  RW  2b/pin: 00 input, 01 push-pull out, 10 AF bridge, 11 open-drain
//     0x04 OUT   RW  output latch       0x08 IN   R   synchronised pad value, all modes
//     0x0C SET   W   OUT |= data        0x10 CLR  W   OUT &= ~data   (both read 0)
//     0x14 RISE_EN RW                   0x18 FALL_EN RW
//     0x1C IRQ_STAT RW1C  edge-latched status
//   Unmapped addresses: read 0, write ignored, ready still pulses.
//   Bus handshake: select=1 & ready=0 -> next cycle ready=1 for exactly one cycle; access
//   (read capture / write commit) happens in that same edge. ready never high two consecutive
//   cycles, so a held select cannot double-commit. Read latency 1 cycle. Writes honour wstrb
//   per byte lane; SET/CLR/W1C apply only to strobed lanes.
//   Pad drive: 01 -> OUT[i]; 10 -> af_for_gpio[i] if af_oe[i] else Z; 11 -> 0 if OUT[i]=0
//   else Z; 00 -> Z. MODE/OUT writes reach the pad the cycle after ready.
//   Input path: pad -> SYNC_STAGES flops -> IN; one more flop holds previous value.
//   rise[i] = IN[i] & ~prev[i]; fall[i] = ~IN[i] & prev[i]. Pad change visible in IN after
//   SYNC_STAGES cycles; IRQ_STAT bit sets one cycle later if its enable is set; irq follows
//   combinationally from registered state.
//   Simultaneity: edge event and W1C to same bit same cycle -> bit stays 1 (set wins).
//   Disabling an enable does not clear an already-set status bit but masks it from irq.
//   Changing MODE never generates spurious edges (detection only on synchronised IN).
//   Reset mid-transaction: ready forced 0; master must re-issue.
// STRUCTURE
//   gpio_pkg: register offsets, MODE encodings (GPIO_MODE_IN/OUT/AF/OD), max-pin constant.
//   Sub-module gpio_pad_cell (one per pin, generate loop): tristate drive mux, synchroniser,
//   prev flop, rise/fall outputs. Top holds registers, bus decode, IRQ_STAT, irq OR-reduce.
// TESTING
//   1 Reset -> read all 8 offsets: 0x0,OUT_RESET,pad-dependent,0,0,0,0,0; gpio all Z.
//   2 MODE=0x5 (pins0,1 out), OUT=0x3, SET=0x4, CLR=0x1 -> OUT reads 0x6; gpio[1:0]=2'b10.
//   3 Write OUT=0xAABB with wstrb=4'b0001 -> OUT low byte 0xBB, upper bits unchanged.
//   4 RISE_EN=0x1, drive gpio[0] 0->1 -> IRQ_STAT=0x1 and irq=1 exactly SYNC_STAGES+1
//     cycles later; write IRQ_STAT=0x1 -> irq drops next cycle.
//   5 Edge on pin0 coincident with W1C of bit0 -> IRQ_STAT bit0 stays 1, irq stays 1.
//   6 MODE pin3=11, OUT[3]=1 with pull-up -> gpio[3]=Z, IN[3]=1; OUT[3]=0 -> gpio[3]=0.

Source files
------------

// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO bank: register offsets, pin mode encodings and bus helpers.
package gpio_pkg;

  localparam int GPIO_MAX_PINS = 16;

  typedef enum logic [1:0] {
    GPIO_MODE_IN  = 2'b00,
    GPIO_MODE_OUT = 2'b01,
    GPIO_MODE_AF  = 2'b10,
    GPIO_MODE_OD  = 2'b11
  } gpio_mode_e;

  // Word index, i.e. addr[4:2].
  typedef enum logic [2:0] {
    REG_MODE     = 3'd0,
    REG_OUT      = 3'd1,
    REG_IN       = 3'd2,
    REG_SET      = 3'd3,
    REG_CLR      = 3'd4,
    REG_RISE_EN  = 3'd5,
    REG_FALL_EN  = 3'd6,
    REG_IRQ_STAT = 3'd7
  } gpio_reg_e;

  function automatic logic [31:0] byte_mask(input logic [3:0] strb);
    return {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
  endfunction

endpackage

// File: rtl/gpio_pad_cell.sv
// One GPIO pin: drive-enable/value selection by mode, input synchroniser and edge detect.
module gpio_pad_cell
  import gpio_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  gpio_mode_e mode,
  input  logic       out_bit,
  input  logic       af_oe,
  input  logic       af_out,
  input  logic       pad_in,
  output logic       drive_en,
  output logic       drive_val,
  output logic       sync_in,
  output logic       rise,
  output logic       fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // NOTE: non-blocking assignments make every flop in the chain sample the pre-edge
  // value of its neighbour; blocking ones would collapse the synchroniser to one stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pad_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_in = sync_q[SYNC_STAGES-1];
  assign rise    = sync_in & ~prev_q;
  assign fall    = ~sync_in & prev_q;

  // NOTE: both outputs get a default first so no path through the case infers a latch.
  always_comb begin
    drive_en  = 1'b0;
    drive_val = 1'b0;
    unique case (mode)
      GPIO_MODE_OUT: begin
        drive_en  = 1'b1;
        drive_val = out_bit;
      end
      GPIO_MODE_AF: begin
        drive_en  = af_oe;
        drive_val = af_out;
      end
      GPIO_MODE_OD: drive_en = ~out_bit;
      default: ;
    endcase
  end

endmodule

// File: rtl/gpio_bank.sv
// Memory-mapped GPIO bank on the picoRV native bus with per-pin mode, edge IRQs and AF bridge.
module gpio_bank
  import gpio_pkg::*;
#(
  parameter int                  NUM_PINS    = 16,
  parameter int                  SYNC_STAGES = 2,
  parameter logic [NUM_PINS-1:0] OUT_RESET   = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                select,
  input  logic [3:0]          wstrb,
  input  logic [4:0]          addr,
  input  logic [31:0]         data_i,
  output logic                ready,
  output logic [31:0]         data_o,
  inout  wire  [NUM_PINS-1:0] gpio,
  input  logic [NUM_PINS-1:0] af_oe,
  input  logic [NUM_PINS-1:0] af_for_gpio,
  output logic [NUM_PINS-1:0] af_from_gpio,
  output logic                irq
);

  localparam int MW = 2 * NUM_PINS;

  logic [MW-1:0]       mode_q;
  logic [NUM_PINS-1:0] out_q, rise_en_q, fall_en_q, irq_stat_q;
  logic [NUM_PINS-1:0] in_sync, rise, fall, drive_en, drive_val, events, w1c;
  logic [31:0]         wmask, wbits, rdata;
  logic                access, wr;
  gpio_reg_e           reg_sel;
  logic                unused_bits;

  assign unused_bits = ^addr[1:0];
  assign reg_sel     = gpio_reg_e'(addr[4:2]);
  assign access      = select & ~ready;
  assign wr          = access & (|wstrb);
  assign wmask       = byte_mask(wstrb);
  assign wbits       = data_i & wmask;
  assign events      = (rise & rise_en_q) | (fall & fall_en_q);
  assign w1c         = (wr && reg_sel == REG_IRQ_STAT) ? wbits[NUM_PINS-1:0] : '0;
  assign irq         = |(irq_stat_q & (rise_en_q | fall_en_q));

  for (genvar i = 0; i < NUM_PINS; i++) begin : g_pin
    gpio_pad_cell #(.SYNC_STAGES(SYNC_STAGES)) u_cell (
      .clk      (clk),
      .reset    (reset),
      .mode     (gpio_mode_e'(mode_q[2*i +: 2])),
      .out_bit  (out_q[i]),
      .af_oe    (af_oe[i]),
      .af_out   (af_for_gpio[i]),
      .pad_in   (gpio[i]),
      .drive_en (drive_en[i]),
      .drive_val(drive_val[i]),
      .sync_in  (in_sync[i]),
      .rise     (rise[i]),
      .fall     (fall[i])
    );
    // Pads float while reset is held, even before the mode register has been cleared.
    assign gpio[i]         = (drive_en[i] & ~reset) ? drive_val[i] : 1'bz;
    assign af_from_gpio[i] = (gpio_mode_e'(mode_q[2*i +: 2]) == GPIO_MODE_AF) & in_sync[i];
  end

  always_comb begin
    rdata = '0;
    unique case (reg_sel)
      REG_MODE:     rdata = 32'(mode_q);
      REG_OUT:      rdata = 32'(out_q);
      REG_IN:       rdata = 32'(in_sync);
      REG_RISE_EN:  rdata = 32'(rise_en_q);
      REG_FALL_EN:  rdata = 32'(fall_en_q);
      REG_IRQ_STAT: rdata = 32'(irq_stat_q);
      default:      rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ready      <= 1'b0;
      data_o     <= '0;
      mode_q     <= '0;
      out_q      <= OUT_RESET;
      rise_en_q  <= '0;
      fall_en_q  <= '0;
      irq_stat_q <= '0;
    end else begin
      ready      <= access;
      data_o     <= (access && wstrb == 4'b0000) ? rdata : '0;
      // A new edge event wins over a simultaneous write-one-to-clear.
      irq_stat_q <= (irq_stat_q & ~w1c) | events;
      if (wr) begin
        unique case (reg_sel)
          REG_MODE:    mode_q    <= (mode_q & ~wmask[MW-1:0]) | wbits[MW-1:0];
          REG_OUT:     out_q     <= (out_q & ~wmask[NUM_PINS-1:0]) | wbits[NUM_PINS-1:0];
          REG_SET:     out_q     <= out_q | wbits[NUM_PINS-1:0];
          REG_CLR:     out_q     <= out_q & ~wbits[NUM_PINS-1:0];
          REG_RISE_EN: rise_en_q <= (rise_en_q & ~wmask[NUM_PINS-1:0]) | wbits[NUM_PINS-1:0];
          REG_FALL_EN: fall_en_q <= (fall_en_q & ~wmask[NUM_PINS-1:0]) | wbits[NUM_PINS-1:0];
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gpio_bank.sv
// Directed self-checking bench for gpio_bank: register map, pad drive, edges and IRQ.
module tb_gpio_bank;

  localparam int N = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          select;
  logic [3:0]    wstrb;
  logic [4:0]    addr;
  logic [31:0]   data_i;
  logic          ready;
  logic [31:0]   data_o;
  wire  [N-1:0]  gpio;
  logic [N-1:0]  af_oe, af_for_gpio, af_from_gpio;
  logic          irq;
  logic [N-1:0]  tb_oe, tb_val;

  int checks = 0;
  int errors = 0;

  gpio_bank #(.NUM_PINS(N), .SYNC_STAGES(2), .OUT_RESET('0)) dut (
    .clk         (clk),
    .reset       (reset),
    .select      (select),
    .wstrb       (wstrb),
    .addr        (addr),
    .data_i      (data_i),
    .ready       (ready),
    .data_o      (data_o),
    .gpio        (gpio),
    .af_oe       (af_oe),
    .af_for_gpio (af_for_gpio),
    .af_from_gpio(af_from_gpio),
    .irq         (irq)
  );

  for (genvar i = 0; i < N; i++) begin : g_pad
    pullup (gpio[i]);
    assign gpio[i] = tb_oe[i] ? tb_val[i] : 1'bz;
  end

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus_xfer(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                          output logic [31:0] q);
    bit done = 0;
    select = 1'b1;
    addr   = a;
    data_i = d;
    wstrb  = s;
    q      = '0;
    for (int i = 0; i < 4 && !done; i++) begin
      @(posedge clk);
      #1;
      if (ready) begin
        done = 1;
        q    = data_o;
      end
    end
    select = 1'b0;
    wstrb  = 4'b0000;
    if (!done) check("bus_timeout", 32'd0, 32'd1);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s = 4'hF);
    logic [31:0] q;
    bus_xfer(a, d, s, q);
  endtask

  task automatic rd(input logic [4:0] a, output logic [31:0] q);
    bus_xfer(a, 32'd0, 4'b0000, q);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [31:0] q;
  logic [31:0] exp_reset [8] = '{32'h0, 32'h0, 32'hFFFF, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};

  initial begin
    reset = 1'b1; select = 1'b1; wstrb = 4'b0000; addr = '0; data_i = '0;
    af_oe = '0; af_for_gpio = '0; tb_oe = '0; tb_val = '0;
    cycles(3);
    check("reset_ready", 32'(ready), 32'd0);
    check("reset_data_o", data_o, 32'd0);
    check("reset_irq", 32'(irq), 32'd0);
    check("reset_pads_z", 32'(gpio), 32'hFFFF);
    select = 1'b0;
    reset  = 1'b0;
    cycles(4);

    // Reset values of every offset; IN reflects the pulled-up idle pads.
    for (int i = 0; i < 8; i++) begin
      rd(5'(i * 4), q);
      check($sformatf("reset_reg_%0d", i), q, exp_reset[i]);
    end
    check("idle_pads_z", 32'(gpio), 32'hFFFF);

    // Push-pull with atomic SET/CLR.
    wr(5'h00, 32'h5);
    wr(5'h04, 32'h3);
    wr(5'h0C, 32'h4);
    wr(5'h10, 32'h1);
    rd(5'h04, q);
    check("out_after_set_clr", q, 32'h6);
    check("pp_pads", 32'(gpio[1:0]), 32'h2);
    rd(5'h0C, q);
    check("set_reads_zero", q, 32'h0);
    cycles(3);
    rd(5'h08, q);
    check("in_pp", q, 32'hFFFE);

    // Byte-lane strobes.
    wr(5'h04, 32'hAABB, 4'b0001);
    rd(5'h04, q);
    check("out_strb_lane0", q, 32'hBB);
    wr(5'h04, 32'hAABB, 4'b0010);
    rd(5'h04, q);
    check("out_strb_lane1", q, 32'hAABB);
    wr(5'h04, 32'h0);
    wr(5'h00, 32'h0);

    // Rise edge on pin0: status and irq exactly SYNC_STAGES+1 cycles after the pad change.
    tb_oe[0] = 1'b1; tb_val[0] = 1'b0;
    cycles(4);
    wr(5'h14, 32'h1);
    @(negedge clk);
    tb_val[0] = 1'b1;
    cycles(2);
    check("irq_before_latency", 32'(irq), 32'd0);
    cycles(1);
    check("irq_at_latency", 32'(irq), 32'd1);
    rd(5'h1C, q);
    check("irq_stat_rise", q, 32'h1);
    wr(5'h1C, 32'h1);
    check("irq_after_w1c", 32'(irq), 32'd0);

    // Set status first, then a new edge lands on the same edge as the W1C commit.
    tb_val[0] = 1'b0; cycles(4);
    tb_val[0] = 1'b1; cycles(4);
    tb_val[0] = 1'b0; cycles(4);
    check("irq_pre_collide", 32'(irq), 32'd1);
    @(negedge clk);
    tb_val[0] = 1'b1;
    cycles(2);
    wr(5'h1C, 32'h1);
    check("irq_collide", 32'(irq), 32'd1);
    rd(5'h1C, q);
    check("stat_collide", q, 32'h1);
    wr(5'h1C, 32'h1);
    rd(5'h1C, q);
    check("stat_cleared", q, 32'h0);

    // Disabled enable masks an already-set bit from irq without clearing it.
    tb_val[0] = 1'b0; cycles(4);
    tb_val[0] = 1'b1; cycles(4);
    wr(5'h14, 32'h0);
    check("irq_masked", 32'(irq), 32'd0);
    rd(5'h1C, q);
    check("stat_kept_masked", q, 32'h1);

    // Open-drain on pin3.
    wr(5'h00, 32'hC0);
    wr(5'h0C, 32'h8);
    check("od_high_z", 32'(gpio[3]), 32'd1);
    cycles(3);
    rd(5'h08, q);
    check("od_in_high", (q >> 3) & 32'h1, 32'd1);
    wr(5'h10, 32'h8);
    check("od_low", 32'(gpio[3]), 32'd0);
    cycles(3);
    rd(5'h08, q);
    check("od_in_low", (q >> 3) & 32'h1, 32'd0);

    // Alternate-function bridge on pin4.
    af_oe[4] = 1'b1; af_for_gpio[4] = 1'b0;
    wr(5'h00, 32'h2C0);
    check("af_drive_low", 32'(gpio[4]), 32'd0);
    cycles(3);
    check("af_from_low", 32'(af_from_gpio), 32'h0);
    af_oe[4] = 1'b0;
    cycles(4);
    check("af_release_z", 32'(gpio[4]), 32'd1);
    check("af_from_high", 32'(af_from_gpio), 32'h10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
